// File: rtl/nq_bus_pkg.sv
// Shared types for the nqcpu memory bus: responder FSM states, bus word, latched request.
package nq_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } nq_state_e;

  typedef logic [15:0] nq_word_t;

  localparam int WAIT_MAX = 15;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
  } nq_req_t;

endpackage

// File: rtl/nq_sram_1rw.sv
// Single-port synchronous RAM: registered read port, write on enable. Contents are never reset.
module nq_sram_1rw #(
  parameter int ADDR_BITS = 10,
  parameter int DW        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DW-1:0]        wdata,
  output logic [DW-1:0]        rdata
);

  logic [DW-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (rst_n && en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/nq_mem_responder.sv
// Windowed RAM responder on the nqcpu bus: fixed wait states, abort on request change,
// sticky error on simultaneous read+write, read data driven onto data_io only in DONE.
module nq_mem_responder
  import nq_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h8000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_i,
  input  logic        re_i,
  input  logic        we_i,
  inout  wire  [15:0] data_io,
  output logic        needWait_o,
  output logic        sel_o,
  output logic        err_o,
  output logic [1:0]  dbg_state,
  output logic [15:0] dbg_accessCount
);

  localparam logic [15:0] WIN_SIZE = 16'(1 << (ADDR_BITS + 1));
  localparam logic [15:0] WIN_MASK = ~(WIN_SIZE - 16'd1);
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES - 1);

  nq_state_e state;
  nq_req_t   req_q;
  logic [3:0] cnt;
  nq_word_t  rdata_q;
  logic      in_win, proto_err, mismatch, commit, need_wait;

  assign in_win    = (addr_i & WIN_MASK) == BASE_ADDR;
  assign sel_o     = in_win & (re_i ^ we_i);
  assign proto_err = in_win & re_i & we_i;
  // Any change of op or address against the latched request (or losing the hit) aborts.
  assign mismatch  = (addr_i != req_q.addr) | (we_i != req_q.we) |
                     (re_i == req_q.we) | !sel_o;

  always_comb begin
    need_wait = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        need_wait = sel_o;
        commit    = sel_o && (WAIT_STATES == 1);
      end
      BUSY: begin
        need_wait = !mismatch;
        commit    = !mismatch && (cnt == 4'd1);
      end
      default: ;
    endcase
  end

  assign needWait_o      = rst_n & need_wait;
  assign dbg_state       = state;
  assign data_io         = (state == DONE && !req_q.we && re_i) ? rdata_q : 'z;

  // At commit the live inputs equal the latched request, so the RAM is fed directly.
  nq_sram_1rw #(.ADDR_BITS(ADDR_BITS), .DW(16)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (commit & rst_n),
    .we    (we_i),
    .addr  (addr_i[ADDR_BITS:1]),
    .wdata (data_io),
    .rdata (rdata_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_q           <= '0;
      cnt             <= '0;
      err_o           <= 1'b0;
      dbg_accessCount <= '0;
    end else begin
      if (proto_err) err_o <= 1'b1;
      case (state)
        IDLE: if (sel_o) begin
          req_q <= '{addr: addr_i, we: we_i};
          cnt   <= CNT_INIT;
          state <= (WAIT_STATES > 1) ? BUSY : DONE;
        end
        BUSY: begin
          if (mismatch) state <= IDLE;
          else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= DONE;
          end
        end
        DONE: begin
          dbg_accessCount <= dbg_accessCount + 16'd1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nq_mem_responder.sv
// Bench: three responders (2, 1 and 4 wait states) on separate pulled-up buses, checked
// against a word-array memory model and access counters kept here.
module tb_nq_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_n, re, we, drv, nw, sel, err;
  logic [2:0][15:0] addr, drv_val, cnt;
  logic [2:0][1:0]  st;
  wire  [15:0]      bus0, bus1, bus2;

  pullup (bus0);
  pullup (bus1);
  pullup (bus2);
  assign bus0 = drv[0] ? drv_val[0] : 16'bz;
  assign bus1 = drv[1] ? drv_val[1] : 16'bz;
  assign bus2 = drv[2] ? drv_val[2] : 16'bz;

  nq_mem_responder #(.WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst_n(rst_n[0]), .addr_i(addr[0]), .re_i(re[0]), .we_i(we[0]),
    .data_io(bus0), .needWait_o(nw[0]), .sel_o(sel[0]), .err_o(err[0]),
    .dbg_state(st[0]), .dbg_accessCount(cnt[0]));
  nq_mem_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n[1]), .addr_i(addr[1]), .re_i(re[1]), .we_i(we[1]),
    .data_io(bus1), .needWait_o(nw[1]), .sel_o(sel[1]), .err_o(err[1]),
    .dbg_state(st[1]), .dbg_accessCount(cnt[1]));
  nq_mem_responder #(.WAIT_STATES(4)) u_ws4 (
    .clk(clk), .rst_n(rst_n[2]), .addr_i(addr[2]), .re_i(re[2]), .we_i(we[2]),
    .data_io(bus2), .needWait_o(nw[2]), .sel_o(sel[2]), .err_o(err[2]),
    .dbg_state(st[2]), .dbg_accessCount(cnt[2]));

  int checks = 0, errors = 0;
  int exp_cnt[3];
  logic [15:0] mdl[3][1024];
  int known_q[$];

  function automatic logic [15:0] bus_of(int d);
    case (d)
      0:       return bus0;
      1:       return bus1;
      default: return bus2;
    endcase
  endfunction

  function automatic int ws_of(int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  // Full request/response handshake: holds the request until the stall ends, samples the bus
  // in the first non-stalled cycle, then drops the request.
  task automatic access(input int d, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output int stalls);
    @(posedge clk); #1;
    addr[d] = a; re[d] = !wr; we[d] = wr; drv[d] = wr; drv_val[d] = wd;
    stalls = 0;
    #4;
    while (nw[d] && stalls < 40) begin
      stalls++;
      @(posedge clk); #5;
    end
    rd = bus_of(d);
    @(posedge clk); #1;
    re[d] = 1'b0; we[d] = 1'b0; drv[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = '0; re = '0; we = '0; drv = '0; addr = '0; drv_val = '0;
    repeat (2) @(posedge clk);
    #5;
    for (int d = 0; d < 3; d++) begin
      checks++; if (st[d] !== 2'd0)   begin errors++; $display("FAIL reset_state[%0d]: got %0d expected 0", d, st[d]); end
      checks++; if (nw[d] !== 1'b0)   begin errors++; $display("FAIL reset_wait[%0d]: got %b expected 0", d, nw[d]); end
      checks++; if (err[d] !== 1'b0)  begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", d, err[d]); end
      checks++; if (cnt[d] !== 16'd0) begin errors++; $display("FAIL reset_count[%0d]: got %0d expected 0", d, cnt[d]); end
      checks++; if (bus_of(d) !== 16'hFFFF) begin errors++; $display("FAIL reset_bus[%0d]: got %h expected released", d, bus_of(d)); end
      exp_cnt[d] = 0;
    end
    @(posedge clk); #1;
    rst_n = '1;
  endtask

  task automatic test_write_read();
    logic [15:0] rd; int n;
    access(0, 1'b1, 16'h8004, 16'hBEEF, rd, n);
    mdl[0][2] = 16'hBEEF; exp_cnt[0]++;
    checks++; if (n !== 2) begin errors++; $display("FAIL wr_stall: got %0d expected 2", n); end
    access(0, 1'b0, 16'h8004, 16'h0000, rd, n);
    exp_cnt[0]++;
    checks++; if (n !== 2) begin errors++; $display("FAIL rd_stall: got %0d expected 2", n); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h expected BEEF", rd); end
    checks++; if (cnt[0] !== 16'd2) begin errors++; $display("FAIL wr_rd_count: got %0d expected 2", cnt[0]); end
  endtask

  task automatic test_out_of_window();
    @(posedge clk); #1;
    addr[0] = 16'h7FFE; re[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #4;
      checks++; if (sel[0] !== 1'b0) begin errors++; $display("FAIL oow_sel: got %b expected 0", sel[0]); end
      checks++; if (nw[0] !== 1'b0)  begin errors++; $display("FAIL oow_wait: got %b expected 0", nw[0]); end
      checks++; if (bus0 !== 16'hFFFF) begin errors++; $display("FAIL oow_bus: got %h expected released", bus0); end
      @(posedge clk); #1;
    end
    re[0] = 1'b0;
    checks++; if (cnt[0] !== 16'(exp_cnt[0])) begin errors++; $display("FAIL oow_count: got %0d expected %0d", cnt[0], exp_cnt[0]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; int n;
    access(1, 1'b1, 16'h8000, 16'h1111, rd, n);
    access(1, 1'b1, 16'h8002, 16'h2222, rd, n);
    exp_cnt[1] += 2;
    checks++; if (n !== 1) begin errors++; $display("FAIL b2b_wr_stall: got %0d expected 1", n); end
    @(posedge clk); #1;
    addr[1] = 16'h8000; re[1] = 1'b1;
    #4;
    checks++; if (nw[1] !== 1'b1) begin errors++; $display("FAIL b2b_stall0: got %b expected 1", nw[1]); end
    @(posedge clk); #5;
    checks++; if (nw[1] !== 1'b0 || bus1 !== 16'h1111) begin errors++; $display("FAIL b2b_data0: got wait=%b bus=%h expected wait=0 bus=1111", nw[1], bus1); end
    @(posedge clk); #1;
    addr[1] = 16'h8002;
    #4;
    checks++; if (nw[1] !== 1'b1 || bus1 !== 16'hFFFF) begin errors++; $display("FAIL b2b_stall1: got wait=%b bus=%h expected wait=1 released", nw[1], bus1); end
    @(posedge clk); #5;
    checks++; if (nw[1] !== 1'b0 || bus1 !== 16'h2222) begin errors++; $display("FAIL b2b_data1: got wait=%b bus=%h expected wait=0 bus=2222", nw[1], bus1); end
    @(posedge clk); #1;
    re[1] = 1'b0; exp_cnt[1] += 2;
    checks++; if (cnt[1] !== 16'(exp_cnt[1])) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", cnt[1], exp_cnt[1]); end
  endtask

  task automatic test_abort();
    logic [15:0] rd, v1; int n;
    v1 = 16'($urandom_range(0, 16'hFFFE));
    access(2, 1'b1, 16'h8010, v1, rd, n);
    exp_cnt[2]++;
    checks++; if (n !== 4) begin errors++; $display("FAIL abort_setup_stall: got %0d expected 4", n); end
    for (int w = 0; w < 2; w++) begin
      @(posedge clk); #1;
      addr[2] = 16'h8010; re[2] = (w == 0); we[2] = (w == 1); drv[2] = (w == 1); drv_val[2] = ~v1;
      #4;
      checks++; if (nw[2] !== 1'b1) begin errors++; $display("FAIL abort_stall0[%0d]: got %b expected 1", w, nw[2]); end
      @(posedge clk); #1;
      re[2] = 1'b0; we[2] = 1'b0;
      #4;
      checks++; if (nw[2] !== 1'b0) begin errors++; $display("FAIL abort_wait_drop[%0d]: got %b expected 0", w, nw[2]); end
      @(posedge clk); #5;
      drv[2] = 1'b0;
      checks++; if (st[2] !== 2'd0) begin errors++; $display("FAIL abort_state[%0d]: got %0d expected 0", w, st[2]); end
      checks++; if (cnt[2] !== 16'(exp_cnt[2])) begin errors++; $display("FAIL abort_count[%0d]: got %0d expected %0d", w, cnt[2], exp_cnt[2]); end
    end
    access(2, 1'b0, 16'h8010, 16'h0, rd, n);
    exp_cnt[2]++;
    checks++; if (rd !== v1) begin errors++; $display("FAIL abort_ram_kept: got %h expected %h", rd, v1); end
  endtask

  task automatic test_protocol_err();
    logic [15:0] rd, v; int n;
    v = 16'($urandom_range(0, 16'hFFFE));
    access(0, 1'b1, 16'h8000, v, rd, n);
    mdl[0][0] = v; exp_cnt[0]++;
    @(posedge clk); #1;
    addr[0] = 16'h8000; re[0] = 1'b1; we[0] = 1'b1; drv[0] = 1'b1; drv_val[0] = ~v;
    #4;
    checks++; if (sel[0] !== 1'b0 || nw[0] !== 1'b0) begin errors++; $display("FAIL perr_nosel: got sel=%b wait=%b expected 0 0", sel[0], nw[0]); end
    @(posedge clk); #5;
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL perr_set: got %b expected 1", err[0]); end
    re[0] = 1'b0; we[0] = 1'b0; drv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #5;
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b expected 1", err[0]); end
    access(0, 1'b0, 16'h8000, 16'h0, rd, n);
    exp_cnt[0]++;
    checks++; if (rd !== v) begin errors++; $display("FAIL perr_ram: got %h expected %h", rd, v); end
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1; exp_cnt[0] = 0;
    #4;
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b expected 0", err[0]); end
  endtask

  task automatic test_reset_busy();
    logic [15:0] rd, v0; int n;
    v0 = 16'($urandom_range(0, 16'hFFFE));
    if (v0 == 16'hAAAA) v0 = 16'h5555;
    access(2, 1'b1, 16'h8020, v0, rd, n);
    exp_cnt[2]++;
    @(posedge clk); #1;
    addr[2] = 16'h8020; we[2] = 1'b1; drv[2] = 1'b1; drv_val[2] = 16'hAAAA;
    repeat (3) @(posedge clk);
    #1;
    rst_n[2] = 1'b0;   // lands on the final BUSY (commit) cycle
    @(posedge clk); #5;
    checks++; if (st[2] !== 2'd0 || nw[2] !== 1'b0) begin errors++; $display("FAIL rstbusy_state: got st=%0d wait=%b expected 0 0", st[2], nw[2]); end
    checks++; if (cnt[2] !== 16'd0 || err[2] !== 1'b0) begin errors++; $display("FAIL rstbusy_regs: got cnt=%0d err=%b expected 0 0", cnt[2], err[2]); end
    we[2] = 1'b0; drv[2] = 1'b0; rst_n[2] = 1'b1; exp_cnt[2] = 0;
    access(2, 1'b0, 16'h8020, 16'h0, rd, n);
    exp_cnt[2]++;
    checks++; if (rd !== v0) begin errors++; $display("FAIL rstbusy_ram: got %h expected %h", rd, v0); end
    checks++; if (cnt[2] !== 16'(exp_cnt[2])) begin errors++; $display("FAIL rstbusy_count: got %0d expected %0d", cnt[2], exp_cnt[2]); end
  endtask

  task automatic test_random();
    logic [15:0] rd, a, wd; int n, idx, r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 2);
      if (r == 1 && known_q.size() == 0) r = 0;
      if (r == 0) begin
        idx = $urandom_range(0, 1023);
        a   = 16'h8000 | 16'(idx << 1) | 16'($urandom_range(0, 1));
        wd  = 16'($urandom_range(0, 16'hFFFE));
        access(0, 1'b1, a, wd, rd, n);
        mdl[0][idx] = wd; known_q.push_back(idx); exp_cnt[0]++;
        checks++; if (n !== ws_of(0)) begin errors++; $display("FAIL rnd_wr_stall[%0d]: got %0d expected %0d", i, n, ws_of(0)); end
      end else if (r == 1) begin
        idx = known_q[$urandom_range(0, known_q.size() - 1)];
        a   = 16'h8000 | 16'(idx << 1);
        access(0, 1'b0, a, 16'h0, rd, n);
        exp_cnt[0]++;
        checks++; if (n !== ws_of(0) || rd !== mdl[0][idx]) begin errors++; $display("FAIL rnd_rd[%0d]: got stall=%0d data=%h expected stall=%0d data=%h", i, n, rd, ws_of(0), mdl[0][idx]); end
      end else begin
        a = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 16'h7FFF)) : 16'($urandom_range(16'h8800, 16'hFFFF));
        access(0, 1'b0, a, 16'h0, rd, n);
        checks++; if (n !== 0 || rd !== 16'hFFFF) begin errors++; $display("FAIL rnd_oow[%0d]: got stall=%0d bus=%h expected 0 released", i, n, rd); end
      end
    end
    checks++; if (cnt[0] !== 16'(exp_cnt[0])) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", cnt[0], exp_cnt[0]); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_out_of_window();
    test_back_to_back();
    test_abort();
    test_protocol_err();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
